aes_spi_frontend: RTL and testbench

Parametrised SPI slave front-end that sits between the external host and an AES core. It replaces the fixed 256-bit load/done shift interface with a clk-domain design: synchronised SPI inputs, configurable block and key widths, key retention across frames, frame-length checking, and an explicit start/done handshake to the core. The block receives a frame over sck/sdi while load is high, launches the core, then shifts the result out on sdo with done high.

---
 rtl/aes_spi_frontend.sv | 159 +++++++++++++++
 tb/tb_aes_spi_frontend.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_spi_frontend.sv
// SPI slave front-end for an AES core: synchronised host inputs, frame capture with
// length checking, key retention across frames, start/done handshake and serial readback.
module aes_spi_frontend #(
  parameter int BLOCK_W     = 128,
  parameter int KEY_W       = 128,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               sck_i,
  input  logic               sdi_i,
  input  logic               load_i,
  output logic               sdo_o,
  output logic               done_o,
  output logic               frame_err_o,
  output logic               core_start_o,
  output logic [BLOCK_W-1:0] core_block_o,
  output logic [KEY_W-1:0]   core_key_o,
  input  logic               core_done_i,
  input  logic [BLOCK_W-1:0] core_result_i
);

  localparam int FRAME_W = BLOCK_W + KEY_W;
  localparam int CW      = $clog2(FRAME_W + 2);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FRAME_W);
  localparam logic [CW-1:0] CNT_BLOCK = CW'(BLOCK_W);
  localparam logic [CW-1:0] CNT_SAT   = CW'(FRAME_W + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BLOCK_W - 1);

  typedef enum logic [2:0] {IDLE, SHIFT_IN, START, BUSY, SHIFT_OUT} state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, sdi_sync_q, load_sync_q;
  logic                   sck_prev_q, load_prev_q;
  logic                   sck_s, sdi_s, load_s;
  logic                   sck_rise, sck_fall, load_rise, load_fall;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [FRAME_W-1:0]     sr_q, sr_d;
  logic [BLOCK_W-1:0]     out_q, out_d;
  logic [BLOCK_W-1:0]     block_q, block_d;
  logic [KEY_W-1:0]       key_q, key_d;
  logic                   key_valid_q, key_valid_d;
  logic                   frame_err_q, frame_err_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_sync_q  <= '0;
      sdi_sync_q  <= '0;
      load_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      load_prev_q <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi_i};
      load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], load_i};
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
      load_prev_q <= load_sync_q[SYNC_STAGES-1];
    end
  end

  assign sck_s     = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
  assign load_s    = load_sync_q[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_prev_q;
  assign sck_fall  = ~sck_s & sck_prev_q;
  assign load_rise = load_s & ~load_prev_q;
  assign load_fall = ~load_s & load_prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      out_q       <= '0;
      block_q     <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      out_q       <= out_d;
      block_q     <= block_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    out_d       = out_q;
    block_d     = block_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    frame_err_d = frame_err_q;
    unique case (state_q)
      IDLE: begin
        if (load_rise) begin
          state_d     = SHIFT_IN;
          cnt_d       = '0;
          frame_err_d = 1'b0;
        end
      end
      SHIFT_IN: begin
        if (load_fall) begin
          if (cnt_q == CNT_FULL) begin
            block_d     = sr_q[FRAME_W-1:KEY_W];
            key_d       = sr_q[KEY_W-1:0];
            key_valid_d = 1'b1;
            state_d     = START;
          end else if (cnt_q == CNT_BLOCK && key_valid_q) begin
            block_d = sr_q[BLOCK_W-1:0];
            state_d = START;
          end else begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end
        end else if (sck_rise) begin
          sr_d = {sr_q[FRAME_W-2:0], sdi_s};
          // Saturate one past a full frame so overlong frames stay distinguishable
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CW'(1);
        end
      end
      START: state_d = BUSY;
      BUSY: begin
        if (core_done_i) begin
          out_d   = core_result_i;
          cnt_d   = '0;
          state_d = SHIFT_OUT;
        end
      end
      SHIFT_OUT: begin
        if (load_rise) begin
          state_d     = SHIFT_IN;
          cnt_d       = '0;
          frame_err_d = 1'b0;
        end else if (sck_fall) begin
          out_d = {out_q[BLOCK_W-2:0], 1'b0};
          if (cnt_q == CNT_LAST) state_d = IDLE;
          else cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign core_start_o = (state_q == START);
  assign done_o       = (state_q == SHIFT_OUT);
  assign sdo_o        = done_o & out_q[BLOCK_W-1];
  assign frame_err_o  = frame_err_q;
  assign core_block_o = block_q;
  assign core_key_o   = key_q;

endmodule

// File: tb/tb_aes_spi_frontend.sv
// Directed bench: a 128-bit-key instance driven from a vector table plus a 256-bit-key
// instance sharing the host pins, each with a fixed-latency core model.
module tb_aes_spi_frontend;

  localparam int HALF = 5;
  localparam logic [127:0] PT1  = 128'h3243F6A8885A308D313198A2E0370734;
  localparam logic [127:0] KEY1 = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
  localparam logic [127:0] RES1 = 128'h3925841D02DC09FBDC118597196A0B32;
  localparam logic [127:0] PT2  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [255:0] KEY2 = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
  localparam logic [127:0] RES2 = 128'h8EA2B7CA516745BFEAFC49904B496089;
  localparam logic [127:0] PT3  = 128'hDEADBEEF0123456789ABCDEFCAFEF00D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sck = 1'b0, sdi = 1'b0, load = 1'b0;

  logic         sdo1, done1, err1, start1, cdone1;
  logic [127:0] block1, key1;
  logic         sdo2, done2, err2, start2, cdone2;
  logic [127:0] block2;
  logic [255:0] key2;

  int tests = 0;
  int fails = 0;
  int starts1 = 0, starts2 = 0;
  int cd_cnt1 = 0, cd_cnt2 = 0;

  always #5 clk = ~clk;

  aes_spi_frontend #(.BLOCK_W(128), .KEY_W(128), .SYNC_STAGES(2)) dut1 (
    .clk_i(clk), .rst_i(rst), .sck_i(sck), .sdi_i(sdi), .load_i(load),
    .sdo_o(sdo1), .done_o(done1), .frame_err_o(err1), .core_start_o(start1),
    .core_block_o(block1), .core_key_o(key1), .core_done_i(cdone1), .core_result_i(RES1)
  );

  aes_spi_frontend #(.BLOCK_W(128), .KEY_W(256), .SYNC_STAGES(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .sck_i(sck), .sdi_i(sdi), .load_i(load),
    .sdo_o(sdo2), .done_o(done2), .frame_err_o(err2), .core_start_o(start2),
    .core_block_o(block2), .core_key_o(key2), .core_done_i(cdone2), .core_result_i(RES2)
  );

  // Core models deliberately ignore rst so a late core_done can arrive after a reset.
  always @(posedge clk) begin
    if (start1) begin
      starts1 <= starts1 + 1;
      cd_cnt1 <= 12;
    end else if (cd_cnt1 != 0) cd_cnt1 <= cd_cnt1 - 1;
    cdone1 <= (cd_cnt1 == 1);
    if (start2) begin
      starts2 <= starts2 + 1;
      cd_cnt2 <= 12;
    end else if (cd_cnt2 != 0) cd_cnt2 <= cd_cnt2 - 1;
    cdone2 <= (cd_cnt2 == 1);
  end

  typedef struct {
    bit           do_rst;
    int           nbits;
    logic [383:0] data;
    bit           exp_err;
    int           exp_starts;
    logic [127:0] exp_block;
    logic [127:0] exp_key;
  } vec_t;

  vec_t vecs[6];

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(1);
  endtask

  task automatic send_frame(input logic [383:0] data, input int nbits);
    load = 1'b1;
    wait_clk(HALF);
    for (int i = nbits - 1; i >= 0; i--) begin
      sdi = data[i];
      wait_clk(HALF);
      sck = 1'b1;
      wait_clk(HALF);
      sck = 1'b0;
    end
    wait_clk(HALF);
    load = 1'b0;
    wait_clk(6);
  endtask

  task automatic wait_done(input bit sel);
    int n;
    n = 0;
    while ((sel ? done2 : done1) !== 1'b1 && n < 100) begin
      wait_clk(1);
      n++;
    end
    check("done_rise_timeout", {383'h0, (sel ? done2 : done1)}, 384'h1);
  endtask

  task automatic read_bits(input bit sel, input int nbits, output logic [127:0] val);
    val = '0;
    for (int i = 0; i < nbits; i++) begin
      val = {val[126:0], (sel ? sdo2 : sdo1)};
      sck = 1'b1;
      wait_clk(HALF);
      sck = 1'b0;
      wait_clk(HALF);
    end
  endtask

  initial begin
    logic [127:0] rd;
    int s0;

    vecs[0] = '{1'b0, 256, {128'h0, PT1, KEY1}, 1'b0, 1, PT1, KEY1};
    vecs[1] = '{1'b0, 128, {256'h0, PT2},       1'b0, 1, PT2, KEY1};
    vecs[2] = '{1'b1, 128, {256'h0, PT2},       1'b1, 0, 128'h0, 128'h0};
    vecs[3] = '{1'b0, 200, {184'h0, 200'hA5_0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978},
                1'b1, 0, 128'h0, 128'h0};
    vecs[4] = '{1'b0, 257, {127'h0, 1'b1, PT1, KEY1}, 1'b1, 0, 128'h0, 128'h0};
    vecs[5] = '{1'b0, 256, {128'h0, PT1, KEY1}, 1'b0, 1, PT1, KEY1};

    rst = 1'b1;
    wait_clk(3);
    check("rst_sdo",   {383'h0, sdo1},   384'h0);
    check("rst_done",  {383'h0, done1},  384'h0);
    check("rst_err",   {383'h0, err1},   384'h0);
    check("rst_start", {383'h0, start1}, 384'h0);
    check("rst_block", {256'h0, block1}, 384'h0);
    check("rst_key",   {256'h0, key1},   384'h0);
    rst = 1'b0;
    wait_clk(2);

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].do_rst) pulse_rst();
      s0 = starts1;
      send_frame(vecs[v].data, vecs[v].nbits);
      check($sformatf("v%0d_err", v),    {383'h0, err1},          {383'h0, vecs[v].exp_err});
      check($sformatf("v%0d_starts", v), 384'(starts1 - s0),      384'(vecs[v].exp_starts));
      check($sformatf("v%0d_block", v),  {256'h0, block1},        {256'h0, vecs[v].exp_block});
      check($sformatf("v%0d_key", v),    {256'h0, key1},          {256'h0, vecs[v].exp_key});
      if (vecs[v].exp_starts != 0) begin
        wait_done(1'b0);
        read_bits(1'b0, 128, rd);
        check($sformatf("v%0d_result", v), {256'h0, rd}, {256'h0, RES1});
        check($sformatf("v%0d_done_fall", v), {383'h0, done1}, 384'h0);
      end else begin
        wait_clk(20);
        check($sformatf("v%0d_no_done", v), {383'h0, done1}, 384'h0);
      end
    end

    // Reset while the core is busy; its later core_done must be ignored.
    s0 = starts1;
    send_frame({128'h0, PT1, KEY1}, 256);
    check("busy_started", 384'(starts1 - s0), 384'd1);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    wait_clk(20);
    check("busy_rst_done",  {383'h0, done1},  384'h0);
    check("busy_rst_sdo",   {383'h0, sdo1},   384'h0);
    check("busy_rst_block", {256'h0, block1}, 384'h0);
    check("busy_rst_key",   {256'h0, key1},   384'h0);
    s0 = starts1;
    send_frame({256'h0, PT2}, 128);
    check("busy_rst_keyvalid_err", {383'h0, err1}, 384'h1);
    check("busy_rst_no_start",     384'(starts1 - s0), 384'd0);

    // 256-bit key instance: split, partial readout, abort by load rise, new block-only frame.
    s0 = starts2;
    send_frame({PT2, KEY2}, 384);
    check("k256_err",   {383'h0, err2},   384'h0);
    check("k256_start", 384'(starts2 - s0), 384'd1);
    check("k256_block", {256'h0, block2}, {256'h0, PT2});
    check("k256_key",   {128'h0, key2},   {128'h0, KEY2});
    wait_done(1'b1);
    read_bits(1'b1, 40, rd);
    check("k256_first40", {256'h0, rd}, {344'h0, RES2[127:88]});
    load = 1'b1;
    wait_clk(8);
    check("k256_abort_done", {383'h0, done2}, 384'h0);
    s0 = starts2;
    send_frame({256'h0, PT3}, 128);
    check("k256_new_err",   {383'h0, err2},   384'h0);
    check("k256_new_start", 384'(starts2 - s0), 384'd1);
    check("k256_new_block", {256'h0, block2}, {256'h0, PT3});
    check("k256_new_key",   {128'h0, key2},   {128'h0, KEY2});
    wait_done(1'b1);
    read_bits(1'b1, 128, rd);
    check("k256_result",    {256'h0, rd},     {256'h0, RES2});
    check("k256_done_fall", {383'h0, done2},  384'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
